bus_arbiter: RTL
================

Name: bus_arbiter

Overview:
- Sits directly downstream of the cpu top.
- Merges the instruction-fetch master (fetch stage) and the memory-access master (post-MMU access stage) onto the single physical TileLink-UL port toward memory/interconnect.
- Registered-grant arbitration. One outstanding transaction at a time; the grant is held from the A-channel request through the D-channel response.
- Memory-access has priority, with a starvation limit that protects fetch.

Parameters:
STARVE_LIMIT, 4, consecutive ma grants allowed while if is waiting before if is forced to win (1..15)
ADDR_W, 64, address width carried in tl_a_t

Ports:
clk  input  1  clock
rst  input  1  reset; synchronous, active-high
if_a_valid  input  1  fetch master A request valid
if_a_ready  output  1  fetch master A accepted
if_a  input  $bits(tl_a_t)  fetch A payload {opcode[2:0], size[2:0], address[ADDR_W-1:0], mask[7:0], data[63:0]}
if_d_valid  output  1  response valid to fetch
if_d_ready  input  1  fetch accepts response
if_d  output  $bits(tl_d_t)  response payload {opcode[2:0], size[2:0], denied, data[63:0]}
ma_a_valid / ma_a_ready / ma_a / ma_d_valid / ma_d_ready / ma_d  same as if_*, for the access master
s_a_valid  output  1  A request to the slave
s_a_ready  input  1  slave accepts A
s_a  output  $bits(tl_a_t)  forwarded A payload
s_d_valid  input  1  slave response valid
s_d_ready  output  1  response accepted
s_d  input  $bits(tl_d_t)  slave response payload
owner  output  2  current grant: 00 none, 01 if, 10 ma
protocol_err  output  1  one-cycle pulse on a D beat with no owner

Behaviour:
- States:
  - IDLE: owner=00.
  - A_PHASE: owner latched.
  - D_PHASE.
- Reset (rst high at posedge): state IDLE, owner 00, starve counter 0. While in reset and the following IDLE cycle, all *_valid/*_ready outputs are 0, except s_d_ready (see below).
- IDLE:
  - If any master's a_valid is high, register the winner into owner and go to A_PHASE next cycle. No A handshake completes in IDLE; minimum request-to-s_a_valid latency is 1 cycle.
  - Winner is ma if ma_a_valid and (!if_a_valid or starve < STARVE_LIMIT); otherwise if.
  - Starve counter: increments (saturating at STARVE_LIMIT) when ma wins while if_a_valid is high; clears to 0 when if wins.
- A_PHASE:
  - s_a_valid = owner's a_valid and s_a = owner's payload, passed through combinationally.
  - Owner's a_ready = s_a_ready; the other master's a_ready = 0.
  - On fire (s_a_valid & s_a_ready): go to D_PHASE.
  - If the owner's a_valid is low (e.g. fetch aborted by pipeline clear): go to IDLE, owner becomes 00, and no transaction is issued.
- D_PHASE:
  - Owner's d_valid = s_d_valid, owner's d = s_d, s_d_ready = owner's d_ready.
  - Non-owner d_valid = 0. s_a_valid = 0; both a_ready = 0.
  - On D fire: go to IDLE. There is one idle bubble before the next grant.
  - A denied response is passed through unchanged; the arbiter does not retry it.
- IDLE with s_d_valid high: s_d_ready = 1 (the beat is dropped) and protocol_err pulses for that cycle.
- Simultaneous requests: resolved only at IDLE per the priority rule.
  - A request that arrives during A_PHASE/D_PHASE waits; the requester must hold a_valid.
- Non-owner payloads are ignored. Non-owner d payload outputs are driven with s_d, but their d_valid is 0.
- rst asserted mid-transaction: the arbiter abandons the state and returns to IDLE. The slave is reset by the same rst.

Decomposition:
- Package tl_pkg holds:
  - typedefs tl_a_t and tl_d_t;
  - TileLink opcode constants (Get=4, PutFull=0, PutPartial=1, AccessAck=0, AccessAckData=1);
  - owner encodings OWN_NONE/OWN_IF/OWN_MA;
  - a state enum.
- One natural sub-module: arb_prio_starve, the combinational winner select plus the starve counter register.

Test Plan:
- Reset, then if_a_valid=1 with a Get at address 0x8000_0000 → s_a_valid=1 one cycle later with s_a.address=0x8000_0000 and owner=01. After s_a_ready and then s_d_valid carrying data 0x13, if_d_valid=1 with data 0x13, then IDLE.
- if and ma both valid at the same cycle → ma granted first (owner=10); if is granted only after ma's D fire plus one idle cycle.
- ma held continuously valid, if valid, STARVE_LIMIT=4 → ma wins 4 consecutive transactions, the 5th grant goes to if, and the counter returns to 0.
- Owner drops if_a_valid in A_PHASE before s_a_ready → s_a_valid=0 the same cycle, state IDLE next cycle, and no D is expected.
- s_d_valid pulsed while IDLE → s_d_ready=1 and protocol_err=1 for exactly one cycle; neither if_d_valid nor ma_d_valid asserts.
- rst asserted during D_PHASE of an ma transaction → next cycle owner=00, all valids 0, and the starve counter is 0.

Source files
------------

// File: rtl/tl_pkg.sv
// TileLink-UL payload types, opcodes and arbiter encodings shared by bus_arbiter and its helpers.
package tl_pkg;

    // Address width is fixed here because the payload structs carry it.
    localparam int ADDR_W = 64;

    localparam logic [2:0] TL_GET             = 3'd4;
    localparam logic [2:0] TL_PUT_FULL        = 3'd0;
    localparam logic [2:0] TL_PUT_PARTIAL     = 3'd1;
    localparam logic [2:0] TL_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] TL_ACCESS_ACK_DATA = 3'd1;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_IF   = 2'b01;
    localparam logic [1:0] OWN_MA   = 2'b10;

    typedef struct packed {
        logic [2:0]        opcode;
        logic [2:0]        size;
        logic [ADDR_W-1:0] address;
        logic [7:0]        mask;
        logic [63:0]       data;
    } tl_a_t;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [2:0]  size;
        logic        denied;
        logic [63:0] data;
    } tl_d_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_A_PHASE = 2'd1,
        ST_D_PHASE = 2'd2
    } arb_state_e;

endpackage

// File: rtl/arb_prio_starve.sv
// Winner select for the fetch/access masters: access wins unless fetch has been passed over
// STARVE_LIMIT consecutive times.
module arb_prio_starve import tl_pkg::*; #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_if_req,
    input  logic i_ma_req,
    input  logic i_grant,
    output logic o_win_ma
);

    localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

    logic [3:0] r_starve;

    assign o_win_ma = i_ma_req && (!i_if_req || (r_starve < LIM));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve <= 4'd0;
        end else if (i_grant) begin
            if (!o_win_ma)
                r_starve <= 4'd0;
            else if (i_if_req && (r_starve < LIM))
                r_starve <= r_starve + 4'd1;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master TileLink-UL arbiter: fetch and memory-access share one slave port, one transaction
// in flight, grant registered in IDLE and held until the D beat is accepted.
module bus_arbiter import tl_pkg::*; #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       if_a_valid,
    output logic       if_a_ready,
    input  tl_a_t      if_a,
    output logic       if_d_valid,
    input  logic       if_d_ready,
    output tl_d_t      if_d,
    input  logic       ma_a_valid,
    output logic       ma_a_ready,
    input  tl_a_t      ma_a,
    output logic       ma_d_valid,
    input  logic       ma_d_ready,
    output tl_d_t      ma_d,
    output logic       s_a_valid,
    input  logic       s_a_ready,
    output tl_a_t      s_a,
    input  logic       s_d_valid,
    output logic       s_d_ready,
    input  tl_d_t      s_d,
    output logic [1:0] owner,
    output logic       protocol_err
);

    arb_state_e r_state, w_state_nxt, w_st;
    logic [1:0] r_owner, w_owner_nxt, w_own;
    logic       w_win_ma, w_grant, w_own_a_valid, w_own_d_ready;

    // Outputs look like IDLE while rst is held so nothing leaks out mid-reset.
    assign w_st  = rst ? ST_IDLE  : r_state;
    assign w_own = rst ? OWN_NONE : r_owner;

    assign w_own_a_valid = (w_own == OWN_MA) ? ma_a_valid :
                           (w_own == OWN_IF) ? if_a_valid : 1'b0;
    assign w_own_d_ready = (w_own == OWN_MA) ? ma_d_ready :
                           (w_own == OWN_IF) ? if_d_ready : 1'b0;

    assign w_grant = (w_st == ST_IDLE) && (if_a_valid || ma_a_valid);

    arb_prio_starve #(.STARVE_LIMIT(STARVE_LIMIT)) u_prio (
        .clk      (clk),
        .rst      (rst),
        .i_if_req (if_a_valid),
        .i_ma_req (ma_a_valid),
        .i_grant  (w_grant),
        .o_win_ma (w_win_ma)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_owner <= OWN_NONE;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        case (r_state)
            ST_IDLE: begin
                if (if_a_valid || ma_a_valid) begin
                    w_state_nxt = ST_A_PHASE;
                    w_owner_nxt = w_win_ma ? OWN_MA : OWN_IF;
                end
            end
            ST_A_PHASE: begin
                // Owner withdrew before acceptance: release without issuing anything.
                if (!w_own_a_valid) begin
                    w_state_nxt = ST_IDLE;
                    w_owner_nxt = OWN_NONE;
                end else if (s_a_ready) begin
                    w_state_nxt = ST_D_PHASE;
                end
            end
            ST_D_PHASE: begin
                if (s_d_valid && w_own_d_ready) begin
                    w_state_nxt = ST_IDLE;
                    w_owner_nxt = OWN_NONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_owner_nxt = OWN_NONE;
            end
        endcase
    end

    always_comb begin
        s_a_valid    = 1'b0;
        s_a          = '0;
        if_a_ready   = 1'b0;
        ma_a_ready   = 1'b0;
        if_d_valid   = 1'b0;
        ma_d_valid   = 1'b0;
        s_d_ready    = 1'b0;
        protocol_err = 1'b0;
        case (w_st)
            ST_IDLE: begin
                // A D beat with nobody waiting is swallowed and flagged.
                s_d_ready    = s_d_valid;
                protocol_err = s_d_valid;
            end
            ST_A_PHASE: begin
                s_a_valid  = w_own_a_valid;
                s_a        = (w_own == OWN_MA) ? ma_a : if_a;
                if_a_ready = (w_own == OWN_IF) && s_a_ready;
                ma_a_ready = (w_own == OWN_MA) && s_a_ready;
            end
            ST_D_PHASE: begin
                if_d_valid = (w_own == OWN_IF) && s_d_valid;
                ma_d_valid = (w_own == OWN_MA) && s_d_valid;
                s_d_ready  = w_own_d_ready;
            end
            default: ;
        endcase
    end

    assign if_d  = s_d;
    assign ma_d  = s_d;
    assign owner = w_own;

endmodule
